tx_dac_frame_serializer: RTL

Parametrised successor to the fixed I/Q DDR byte interleaver for the DAC transmit path. It accepts one multi-channel I/Q sample set per frame through a valid/ready handshake. It serialises the set word by word (I0,Q0,I1,Q1,...) onto MSB/LSB byte lanes for external ODDRs, and generates a DAC FRAME signal with a programmable extended-frame multi-DAC sync sequence. It runs entirely in the 2x DAC clock domain, sitting between the radio TX datapath and the LVDS output primitives. Underflows are handled with filler frames and reported.

---
 rtl/tx_dac_frame_serializer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tx_dac_frame_serializer.sv
// tx_dac_frame_serializer
// Serialises one multi-channel I/Q sample set per frame onto MSB/LSB byte
// lanes for external ODDRs and generates the DAC FRAME signal, including an
// extended multi-DAC sync sequence. When no set is offered at a frame
// boundary, a filler frame is sent so the FRAME cadence never breaks.
// Optional build macro: TX_SER_UNDERFLOW_CNT_EN adds a 16-bit saturating
// underflow_cnt output, cleared by reset and by a rising edge of en.
module tx_dac_frame_serializer #(
  parameter int NUM_CHAN       = 1,
  parameter int LANE_W         = 8,
  parameter int FRAME_HI_WORDS = 1,
  parameter int SYNC_HI_WORDS  = 3,
  parameter int HOLD_LAST      = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           en,
  input  logic [2*NUM_CHAN*2*LANE_W-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sync_req,
  output logic [LANE_W-1:0]              out_d1,
  output logic [LANE_W-1:0]              out_d2,
  output logic                           out_frame,
  output logic                           frame_start,
  output logic                           underflow,
  output logic                           sync_done
`ifdef TX_SER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                    underflow_cnt
`endif
);

  localparam int WORDS  = 2 * NUM_CHAN;
  localparam int SW     = 2 * LANE_W;
  localparam int SET_W  = WORDS * SW;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FCNT_W = $clog2(2 * WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WCNT_W-1:0]   wcnt;
  logic [SET_W-1:0]    set_buf;
  logic [FCNT_W-1:0]   fcnt;
  logic [FCNT_W-1:0]   fcnt_dec;
  logic [FCNT_W-1:0]   fcnt_norm;
  logic [SW-1:0]       cur_word;
  logic                last_word;
  logic                active;
  logic                load_set;
  logic                load_filler;
  logic                advance;
  logic                frame_begin;
  logic                sync_r;
  logic                sync_r2;
  logic                sync_rise;
  logic                sync_pend;
  logic                underflow_q;
  logic                sync_done_q;

  assign last_word   = (wcnt == WCNT_W'(WORDS - 1));
  assign active      = (state != IDLE);
  assign frame_begin = load_set | load_filler;
  assign sync_rise   = sync_r & ~sync_r2;

  // Next-state, handshake and word-advance decisions for the frame sequencer
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    load_set    = 1'b0;
    load_filler = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = en;
        if (en && in_valid) begin
          load_set  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_word) begin
          in_ready = en;
          if (en && in_valid) begin
            load_set = 1'b1;
          end else if (en) begin
            load_filler = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          advance = 1'b1;
          if (!en) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_word) begin
          state_nxt = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word counter: restarts at every frame start and whenever the FSM idles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
    end else if (frame_begin || (state_nxt == IDLE)) begin
      wcnt <= '0;
    end else if (advance) begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

  // Set buffer; with HOLD_LAST it already holds the last accepted set, so a
  // filler frame simply keeps it, otherwise the filler is all zeros
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_buf <= '0;
    end else if (load_set) begin
      set_buf <= in_data;
    end else if (load_filler) begin
      set_buf <= (HOLD_LAST != 0) ? set_buf : '0;
    end
  end

  // Select the word currently on the lanes
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (wcnt == WCNT_W'(k)) begin
        cur_word = set_buf[k*SW +: SW];
      end
    end
  end

  assign out_d1      = active ? cur_word[SW-1:LANE_W] : '0;
  assign out_d2      = active ? cur_word[LANE_W-1:0]  : '0;
  assign frame_start = active && (wcnt == '0);

  assign fcnt_dec  = (fcnt != '0) ? (fcnt - FCNT_W'(1)) : '0;
  assign fcnt_norm = (fcnt_dec > FCNT_W'(FRAME_HI_WORDS)) ? fcnt_dec
                                                          : FCNT_W'(FRAME_HI_WORDS);

  // FRAME-high counter; a long sync run carries its remainder into the
  // next frame, and it is forced clear when the serializer goes idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt <= '0;
    end else if (frame_begin) begin
      fcnt <= sync_pend ? FCNT_W'(SYNC_HI_WORDS) : fcnt_norm;
    end else if (state_nxt == IDLE) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt_dec;
    end
  end

  assign out_frame = (fcnt != '0);

  // Sync request capture: register, detect rising edge, hold until the next
  // frame start; an edge landing on the consuming cycle stays pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r    <= 1'b0;
      sync_r2   <= 1'b0;
      sync_pend <= 1'b0;
    end else begin
      sync_r    <= sync_req;
      sync_r2   <= sync_r;
      sync_pend <= (sync_pend & ~frame_begin) | sync_rise;
    end
  end

  // Status pulses aligned with frame_start of the frame they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      underflow_q <= load_filler;
      sync_done_q <= frame_begin & sync_pend;
    end
  end

  assign underflow = underflow_q;
  assign sync_done = sync_done_q;

`ifdef TX_SER_UNDERFLOW_CNT_EN
  logic        en_q;
  logic [15:0] uf_cnt;

  // Saturating filler-frame counter, restarted whenever en rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b0;
      uf_cnt <= '0;
    end else begin
      en_q <= en;
      if (en && !en_q) begin
        uf_cnt <= '0;
      end else if (load_filler && (uf_cnt != 16'hFFFF)) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end
  end

  assign underflow_cnt = uf_cnt;
`endif

endmodule
